// File: rtl/uart_prog_loader.sv
// Serial program loader: 8N1 UART receiver feeding a framed, XOR-checked image
// into the core's 32-entry instruction memory; cpu_run is released only on a good frame.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT  = 16,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic       mem_we,
  output logic [4:0] mem_addr,
  output logic [7:0] mem_data,
  output logic       cpu_run,
  output logic       load_done,
  output logic       load_err,
  output logic       busy
);
  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int TMO = TIMEOUT_BYTES * 10 * CLKS_PER_BIT;
  localparam int TW  = $clog2(TMO + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TMO_M1  = TW'(TMO - 1);
  localparam logic [7:0]    SYNC    = 8'hA5;

  // state     | meaning
  // WAIT_SYNC | hunting for 0xA5, core held off
  // GET_LEN   | expecting LEN byte
  // GET_DATA  | writing LEN bytes to memory
  // GET_SUM   | expecting CHK byte
  // DONE      | image valid, core running
  // ERROR     | frame rejected, core held off
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {WAIT_SYNC, GET_LEN, GET_DATA, GET_SUM, DONE, ERROR} state_e;

  logic          rx_s1_q, rx_s2_q;
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_err_q, frame_err_d;

  state_e        state_q, state_d;
  logic [7:0]    xor_q, xor_d;
  logic [5:0]    idx_q, idx_d;
  logic [5:0]    len_q, len_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          we_q, we_d;
  logic [4:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_sh_d      = rx_sh_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (rx_state_q != RX_IDLE) rx_cnt_d = rx_cnt_q - CW'(1);
    unique case (rx_state_q)
      RX_IDLE: if (!rx_s2_q) begin
        rx_state_d = RX_START;
        rx_cnt_d   = HALF_M1;
      end
      RX_START: if (rx_cnt_q == '0) begin
        if (rx_s2_q) rx_state_d = RX_IDLE;  // start bit vanished: glitch
        else begin
          rx_state_d = RX_DATA;
          rx_cnt_d   = FULL_M1;
          rx_bit_d   = '0;
        end
      end
      RX_DATA: if (rx_cnt_q == '0) begin
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_cnt_d = FULL_M1;
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == '0) begin
        rx_state_d   = RX_IDLE;
        byte_valid_d = rx_s2_q;
        frame_err_d  = !rx_s2_q;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_sh_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_s1_q      <= rx_i;
      rx_s2_q      <= rx_s1_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_sh_q      <= rx_sh_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign busy = (state_q == GET_LEN) || (state_q == GET_DATA) || (state_q == GET_SUM);

  always_comb begin
    state_d = state_q;
    xor_d   = xor_q;
    idx_d   = idx_q;
    len_d   = len_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    tmo_d   = (tmo_q != '0) ? tmo_q - TW'(1) : tmo_q;
    if (byte_valid_q) tmo_d = TMO_M1;
    unique case (state_q)
      WAIT_SYNC, DONE, ERROR:
        if (byte_valid_q && rx_sh_q == SYNC) state_d = GET_LEN;
      GET_LEN: if (byte_valid_q) begin
        if (rx_sh_q == 8'd0 || rx_sh_q > 8'd32) state_d = ERROR;
        else begin
          state_d = GET_DATA;
          len_d   = rx_sh_q[5:0];
          xor_d   = rx_sh_q;
          idx_d   = '0;
        end
      end
      GET_DATA: if (byte_valid_q) begin
        we_d   = 1'b1;
        addr_d = idx_q[4:0];
        data_d = rx_sh_q;
        xor_d  = xor_q ^ rx_sh_q;
        idx_d  = idx_q + 6'd1;
        if (idx_q + 6'd1 == len_q) state_d = GET_SUM;
      end
      GET_SUM: if (byte_valid_q) begin
        if (rx_sh_q == xor_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else state_d = ERROR;
      end
      default: state_d = WAIT_SYNC;
    endcase
    // tmo_q is reloaded on every completed byte, so zero here means silence too long
    if (busy && (frame_err_q || (tmo_q == '0 && !byte_valid_q))) state_d = ERROR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_SYNC;
      xor_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xor_q   <= xor_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_data  = data_q;
  assign load_done = done_q;
  assign cpu_run   = (state_q == DONE);
  assign load_err  = (state_q == ERROR);

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: UART byte driver, write/pulse monitor, and a
// frame-parsing reference model over the whole byte history since reset.
module tb_uart_prog_loader;
  localparam int CPB = 16;

  typedef struct {
    logic [7:0] d;
    bit         ferr;
    bit         sil;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_i = 1'b1;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_data;
  logic       cpu_run, load_done, load_err, busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int obs_done = 0;
  int bad_align = 0;
  int exp_done;
  logic exp_run, exp_err, exp_busy;
  ev_t hist[$];
  logic [12:0] obs_w[$];
  logic [12:0] exp_w[$];
  int obs_wc[$];

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_BYTES(4)) dut (
    .clk(clk), .rst(rst), .rx_i(rx_i),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .cpu_run(cpu_run), .load_done(load_done), .load_err(load_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      obs_w.push_back({mem_addr, mem_data});
      obs_wc.push_back(cyc);
    end
    if (load_done) obs_done++;
    if (load_done && !cpu_run) bad_align++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit broken(input ev_t e);
    return e.ferr || e.sil;
  endfunction

  // Parse the history: SYNC, LEN, LEN data bytes, CHK; a broken event inside a frame rejects it.
  function automatic void model_run();
    int i, j, k, n, len;
    logic [7:0] x;
    bit fail;
    exp_w.delete();
    exp_done = 0; exp_run = 0; exp_err = 0; exp_busy = 0;
    n = hist.size();
    i = 0;
    while (i < n) begin
      if (broken(hist[i]) || hist[i].d != 8'hA5) begin
        i++;
        continue;
      end
      exp_run = 0; exp_err = 0;
      if (i + 1 >= n) begin exp_busy = 1; return; end
      len = int'(hist[i+1].d);
      if (broken(hist[i+1]) || len < 1 || len > 32) begin
        exp_err = 1;
        i += 2;
        continue;
      end
      x = hist[i+1].d;
      fail = 0;
      k = 0;
      while (!fail && k <= len) begin
        j = i + 2 + k;
        if (j >= n) begin exp_busy = 1; return; end
        if (broken(hist[j])) fail = 1;
        else if (k < len) begin
          exp_w.push_back({5'(k), hist[j].d});
          x ^= hist[j].d;
        end else if (hist[j].d != x) fail = 1;
        k++;
      end
      i = i + 2 + k;
      if (fail) exp_err = 1;
      else begin exp_run = 1; exp_done++; end
    end
  endfunction

  task automatic check_all(input string tag);
    model_run();
    chk({tag, ":nwrites"}, obs_w.size(), exp_w.size());
    for (int k = 0; k < exp_w.size() && k < obs_w.size(); k++)
      chk($sformatf("%s:write%0d", tag, k), obs_w[k], exp_w[k]);
    chk({tag, ":done_cnt"}, obs_done, exp_done);
    chk({tag, ":cpu_run"}, cpu_run, exp_run);
    chk({tag, ":load_err"}, load_err, exp_err);
    chk({tag, ":busy"}, busy, exp_busy);
  endtask

  // Entered and left on a negedge so gap=0 gives back-to-back frames.
  task automatic send_byte(input logic [7:0] b, input bit bad_stop, input int gap);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_i = !bad_stop;
    repeat (CPB) @(negedge clk);
    rx_i = 1'b1;
    repeat (gap) @(negedge clk);
    hist.push_back('{d: b, ferr: bad_stop, sil: 1'b0});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ":mem_we"}, mem_we, 0);
    chk({tag, ":mem_addr"}, mem_addr, 0);
    chk({tag, ":mem_data"}, mem_data, 0);
    chk({tag, ":cpu_run"}, cpu_run, 0);
    chk({tag, ":load_done"}, load_done, 0);
    chk({tag, ":load_err"}, load_err, 0);
    chk({tag, ":busy"}, busy, 0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    rx_i = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero(tag);
    hist.delete(); obs_w.delete(); obs_wc.delete();
    obs_done = 0;
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b, x;
    int len, t0, w, lat;

    do_reset("reset");

    // wrong checksum, then the same frame with the right one
    send_byte(8'hA5, 0, 3); send_byte(8'h03, 0, 3);
    t0 = cyc;
    send_byte(8'h01, 0, 3); send_byte(8'h2A, 0, 3); send_byte(8'h0A, 0, 3);
    send_byte(8'h00, 0, 3);
    repeat (2) @(negedge clk);
    lat = (obs_wc.size() > 0) ? obs_wc[0] - t0 : -1;
    chk("latency_156pm1", (lat >= 155 && lat <= 157), 1);
    chk("badchk:err", load_err, 1);
    check_all("badchk");
    send_byte(8'hA5, 0, 3);
    chk("sync_clears_err", load_err, 0);
    chk("sync_busy", busy, 1);
    send_byte(8'h03, 0, 0); send_byte(8'h01, 0, 0); send_byte(8'h2A, 0, 0);
    send_byte(8'h0A, 0, 0); send_byte(8'h22, 0, 2);
    chk("goodchk:run", cpu_run, 1);
    check_all("goodchk");

    // 32-byte frame with no idle between bytes
    send_byte(8'hA5, 0, 0); send_byte(8'd32, 0, 0);
    x = 8'd32;
    for (int i = 0; i < 32; i++) begin
      b = 8'($urandom_range(0, 255));
      x ^= b;
      send_byte(b, 0, 0);
    end
    send_byte(x, 0, 2);
    check_all("len32");

    send_byte(8'hA5, 0, 2); send_byte(8'h00, 0, 2);
    check_all("len0");
    send_byte(8'hA5, 0, 2); send_byte(8'h21, 0, 2);
    check_all("len33");

    // randomized frames with optional garbage in front and random gaps
    for (int f = 0; f < 4; f++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        send_byte(b, 0, $urandom_range(0, 12));
      end
      len = $urandom_range(1, 20);
      send_byte(8'hA5, 0, $urandom_range(0, 12));
      send_byte(8'(len), 0, $urandom_range(0, 12));
      x = 8'(len);
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom_range(0, 255));
        x ^= b;
        send_byte(b, 0, $urandom_range(0, 12));
      end
      if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
      send_byte(x, 0, 2);
      check_all($sformatf("rnd%0d", f));
    end

    // inter-byte timeout
    send_byte(8'hA5, 0, 0); send_byte(8'h02, 0, 0); send_byte(8'h11, 0, 0);
    chk("tmo:busy_before", busy, 1);
    for (w = 0; w < 1000 && !load_err; w++) @(negedge clk);
    chk("tmo:err_seen", load_err, 1);
    lat = cyc - obs_wc[$];
    chk("tmo:640pm1", (lat >= 639 && lat <= 641), 1);
    hist.push_back('{d: 8'h00, ferr: 1'b0, sil: 1'b1});
    check_all("timeout");

    // framing error on the second data byte
    send_byte(8'hA5, 0, 0); send_byte(8'h02, 0, 0); send_byte(8'h11, 0, 0);
    send_byte(8'($urandom_range(0, 255)), 1, 20);
    check_all("framing");

    // garbage then a one-byte frame
    send_byte(8'h00, 0, 4); send_byte(8'hFF, 0, 4);
    send_byte(8'hA5, 0, 0); send_byte(8'h01, 0, 0); send_byte(8'h0A, 0, 0);
    send_byte(8'h0B, 0, 2);
    check_all("garbage");
    chk("bad_align", bad_align, 0);

    // reset in the middle of a frame
    send_byte(8'hA5, 0, 0);
    chk("midrst:run_drops", cpu_run, 0);
    rx_i = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("midrst");
    do_reset("midrst2");
    send_byte(8'hA5, 0, 1); send_byte(8'h02, 0, 1);
    send_byte(8'h5C, 0, 1); send_byte(8'hC3, 0, 1);
    send_byte(8'h02 ^ 8'h5C ^ 8'hC3, 0, 2);
    chk("after_rst:run", cpu_run, 1);
    check_all("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Serial program loader that sits directly upstream of the 8-bit accumulator core's 32-entry instruction memory. Receives a framed program image over an 8N1 UART line, writes each byte into instruction memory through a one-cycle write strobe, verifies an XOR checksum, and only then releases the core via `cpu_run`. It replaces manual byte-by-byte loading through the write-enable pins.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit; even, minimum 4.
- `TIMEOUT_BYTES`, default 4: inter-byte timeout, in byte times (10 × `CLKS_PER_BIT` clocks each).
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_i`  in  1  UART serial input, idle high, asynchronous to `clk`.
- `mem_we`  out  1  one-cycle instruction-memory write strobe.
- `mem_addr`  out  5  write address, 0..31.
- `mem_data`  out  8  write data.
- `cpu_run`  out  1  high means the image is valid and the core may execute; low holds the core off.
- `load_done`  out  1  one-cycle pulse when a frame passes its checksum.
- `load_err`  out  1  level; frame rejected; cleared by the next sync byte or by reset.
- `busy`  out  1  high while a frame is in progress.

## Operation
- Frame format: SYNC `0xA5`, then LEN (1..32), then LEN data bytes (written to addresses 0..LEN-1), then CHK. CHK must equal LEN XOR all data bytes.
- RX front end:
  - `rx_i` passes through a 2-flop synchronizer.
  - A falling edge in idle starts a bit counter. The start bit is re-sampled at `CLKS_PER_BIT/2`; if it is high, the event is a glitch and is ignored.
  - 8 data bits are sampled LSB-first, each `CLKS_PER_BIT` after the previous sample. The stop bit is sampled the same way.
  - Stop = 1 raises an internal `byte_valid` pulse. Stop = 0 is a framing error; the byte is discarded.
- Protocol FSM states: WAIT_SYNC, GET_LEN, GET_DATA, GET_SUM, DONE, ERROR.
  - WAIT_SYNC: non-`0xA5` bytes and framing errors are ignored. `0xA5` → GET_LEN, `cpu_run`←0.
  - GET_LEN: LEN in 1..32 → GET_DATA; the running XOR is set to LEN and the index to 0. LEN = 0 or LEN > 32 → ERROR.
  - GET_DATA: each byte drives one `mem_we` pulse with `mem_addr`=index and `mem_data`=byte, then the XOR is updated and the index incremented. After byte LEN → GET_SUM.
  - GET_SUM: CHK equal to the running XOR → DONE. Any other value → ERROR.
  - DONE: `cpu_run`=1. A `0xA5` byte starts a new load (→ GET_LEN, `cpu_run`←0); other bytes are ignored.
  - ERROR: `load_err`=1, `cpu_run`=0. A `0xA5` byte → GET_LEN and clears `load_err`.
- A framing error in GET_LEN, GET_DATA or GET_SUM → ERROR.
- Inter-byte timeout: in GET_LEN, GET_DATA or GET_SUM, if no completed byte arrives within `TIMEOUT_BYTES`×10×`CLKS_PER_BIT` clocks of the previous byte → ERROR.
- Memory writes are not rolled back on error. `cpu_run` gating is the only protection.
- `busy` = state ∈ {GET_LEN, GET_DATA, GET_SUM}.

## Timing
- Reset: every output is 0 (`mem_we`, `mem_addr`, `mem_data`, `cpu_run`, `load_done`, `load_err`, `busy`). The FSM goes to WAIT_SYNC and the RX front end to idle.
- Reset mid-load aborts the load. Memory keeps its partial contents and `cpu_run` stays 0 until a full good frame is received.
- `byte_valid` is asserted the cycle after the stop-bit sample clock.
- The FSM reacts in the same cycle as `byte_valid`, and every output registers one cycle after `byte_valid`. For data bytes: `mem_we`=1 for exactly that one cycle, with `mem_addr`/`mem_data` valid in the same cycle. `mem_addr`/`mem_data` hold their values afterwards.
- Byte latency: from the falling start edge to `mem_we` is 2 (sync) + `CLKS_PER_BIT`/2 + 9×`CLKS_PER_BIT` + 2 cycles, ±1.
- `cpu_run` and `load_done` rise in the same cycle, one cycle after the CHK byte's `byte_valid`.
- `cpu_run` falls one cycle after a SYNC byte's `byte_valid`.
- Back-to-back bytes with no idle time between stop and start bits must be received without loss.
- The index cannot wrap: LEN ≤ 32 is enforced before any write.

## Test plan
- `CLKS_PER_BIT`=16; frame A5 03 01 2A 0A (CHK = 03^01^2A^0A = 22) sent with the wrong CHK 0x00 → `load_err`=1, `cpu_run`=0, and 3 writes still occurred. Then the same frame with CHK = 0x22 → 3 writes: addr0=01, addr1=2A, addr2=0A; one `load_done` pulse; `cpu_run`=1; `load_err` clears at the SYNC byte.
- Garbage 0x00 0xFF then A5 01 0A 0B → garbage ignored, one write (addr0=0A), `cpu_run`=1.
- A5 00 → ERROR, `load_err`=1, no writes. A5 21 → ERROR, no writes.
- Valid 32-byte frame sent back-to-back with no idle gaps → 32 writes to addresses 0..31, `cpu_run`=1.
- A5 02 11 followed by silence → ERROR after 640 clocks (4×10×16) of no byte, `busy` falls. In a separate run, a stop bit forced low on the second data byte → immediate ERROR.
- With `cpu_run`=1, send A5 and assert `rst` mid-frame → all outputs 0, state WAIT_SYNC; a subsequent good frame sets `cpu_run`=1.
